// File: rtl/acc_dispatch_ctrl.sv
// rtl/acc_dispatch_ctrl.sv - accelerator dispatch: issue FIFO, in-flight tracking, flush/drain, writeback
module acc_dispatch_ctrl #(
    parameter int XLEN            = 64,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TRANS_ID_W      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [XLEN-1:0]       issue_rs1_i,
    input  logic [XLEN-1:0]       issue_rs2_i,
    input  logic [TRANS_ID_W-1:0] issue_trans_id_i,
    output logic                  acc_req_valid_o,
    input  logic                  acc_req_ready_i,
    output logic [31:0]           acc_req_instr_o,
    output logic [XLEN-1:0]       acc_req_rs1_o,
    output logic [XLEN-1:0]       acc_req_rs2_o,
    output logic [TRANS_ID_W-1:0] acc_req_trans_id_o,
    input  logic                  acc_resp_valid_i,
    input  logic [TRANS_ID_W-1:0] acc_resp_trans_id_i,
    input  logic [XLEN-1:0]       acc_resp_result_i,
    input  logic                  acc_resp_error_i,
    output logic                  wb_valid_o,
    output logic [TRANS_ID_W-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]       wb_result_o,
    output logic                  wb_ex_valid_o,
    output logic [3:0]            inflight_o,
    output logic                  idle_o,
    output logic                  unexpected_resp_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [31:0]           instr_mem [DEPTH];
    logic [XLEN-1:0]       rs1_mem   [DEPTH];
    logic [XLEN-1:0]       rs2_mem   [DEPTH];
    logic [TRANS_ID_W-1:0] tid_mem   [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [3:0]            inflight;
    logic [3:0]            inflight_next;

    logic run;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic resp_ok;
    logic resp_stray;

    assign run        = (state == RUN);
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign resp_ok    = acc_resp_valid_i && (inflight != 4'd0);
    assign resp_stray = acc_resp_valid_i && (inflight == 4'd0);

    assign issue_ready_o   = run && !full && !flush_i;
    assign acc_req_valid_o = run && !empty && (inflight < 4'(MAX_OUTSTANDING)) && !flush_i;
    assign push            = issue_valid_i && issue_ready_o;
    assign pop             = acc_req_valid_o && acc_req_ready_i;

    // Head of queue is shown directly; it only moves on pop, so payload holds while stalled
    assign acc_req_instr_o    = instr_mem[rd_ptr];
    assign acc_req_rs1_o      = rs1_mem[rd_ptr];
    assign acc_req_rs2_o      = rs2_mem[rd_ptr];
    assign acc_req_trans_id_o = tid_mem[rd_ptr];

    assign inflight_o = inflight;
    assign idle_o     = run && empty && (inflight == 4'd0);

    // Net in-flight change: a fire and an accepted response in one cycle cancel out
    always_comb begin
        inflight_next = inflight;
        case ({pop, resp_ok})
            2'b10:   inflight_next = inflight + 4'd1;
            2'b01:   inflight_next = inflight - 4'd1;
            default: inflight_next = inflight;
        endcase
    end

    // Flush in RUN drains outstanding work; DRAIN exits once nothing is outstanding and no flush is held
    always_comb begin
        state_next = state;
        if (state == RUN) begin
            if (flush_i && (inflight_next != 4'd0)) begin
                state_next = DRAIN;
            end
        end else begin
            if ((inflight_next == 4'd0) && !flush_i) begin
                state_next = RUN;
            end
        end
    end

    // Queue pointers and occupancy; a flush in RUN discards every queued entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (run && flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr] <= issue_instr_i;
            rs1_mem[wr_ptr]   <= issue_rs1_i;
            rs2_mem[wr_ptr]   <= issue_rs2_i;
            tid_mem[wr_ptr]   <= issue_trans_id_i;
        end
    end

    // FSM, in-flight counter and sticky stray-response flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= RUN;
            inflight          <= 4'd0;
            unexpected_resp_o <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            if (resp_stray) begin
                unexpected_resp_o <= 1'b1;
            end
        end
    end

    // Registered writeback; responses arriving while draining or flushing are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_o    <= 1'b0;
            wb_trans_id_o <= '0;
            wb_result_o   <= '0;
            wb_ex_valid_o <= 1'b0;
        end else begin
            wb_valid_o <= run && resp_ok && !flush_i;
            if (run && resp_ok && !flush_i) begin
                wb_trans_id_o <= acc_resp_trans_id_i;
                wb_result_o   <= acc_resp_result_i;
                wb_ex_valid_o <= acc_resp_error_i;
            end
        end
    end

endmodule

// File: doc/acc_dispatch_ctrl.md
ACC_DISPATCH_CTRL -- requirements
Module: acc_dispatch_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have parameter DEPTH, default 4, issue queue entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, accelerator in-flight limit (1..15).
REQ-004 SHALL have parameter TRANS_ID_W, default 3, scoreboard transaction-ID width.
REQ-005 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset). The design uses one clock, and reset is synchronous and active-high.
REQ-006 SHALL have ports flush_i in 1 (pipeline flush), issue_valid_i in 1, issue_ready_o out 1, issue_instr_i in 32, issue_rs1_i in XLEN, issue_rs2_i in XLEN, issue_trans_id_i in TRANS_ID_W.
REQ-007 SHALL have ports acc_req_valid_o out 1, acc_req_ready_i in 1, acc_req_instr_o out 32, acc_req_rs1_o out XLEN, acc_req_rs2_o out XLEN, acc_req_trans_id_o out TRANS_ID_W.
REQ-008 SHALL have ports acc_resp_valid_i in 1, acc_resp_trans_id_i in TRANS_ID_W, acc_resp_result_i in XLEN, acc_resp_error_i in 1 (no ready; the accelerator never stalls a response).
REQ-009 SHALL have ports wb_valid_o out 1, wb_trans_id_o out TRANS_ID_W, wb_result_o out XLEN, wb_ex_valid_o out 1, inflight_o out 4, idle_o out 1, unexpected_resp_o out 1.

Function
REQ-010 SHALL hold offloaded instructions in a DEPTH-entry FIFO of {instr, rs1, rs2, trans_id} with wrapping read/write pointers plus a count.
REQ-011 SHALL set issue_ready_o = (state==RUN) && !full && !flush_i; a push occurs on issue_valid_i && issue_ready_o.
REQ-012 SHALL drive acc_req_* from the FIFO head (show-ahead). The request is valid as acc_req_valid_o = (state==RUN) && !empty && (inflight < MAX_OUTSTANDING) && !flush_i.
REQ-013 SHALL pop the head on acc_req_valid_o && acc_req_ready_i. A simultaneous push and pop leaves the count unchanged; there is no bypass, so a pushed entry is offered no earlier than the next cycle.
REQ-014 SHALL keep acc_req_* payload stable while acc_req_valid_o is high and not accepted.
REQ-015 SHALL increment inflight on a request fire and decrement it on acc_resp_valid_i. If both occur in the same cycle, inflight is unchanged. inflight_o = inflight.
REQ-016 SHALL, on acc_resp_valid_i with inflight==0, ignore the response (no writeback, no decrement) and set sticky unexpected_resp_o, which is cleared only by reset.
REQ-017 SHALL register responses. In RUN, wb_valid_o, wb_trans_id_o, wb_result_o and wb_ex_valid_o (=acc_resp_error_i) appear exactly 1 cycle after acc_resp_valid_i. wb_valid_o lasts 1 cycle per response, and back-to-back responses give back-to-back writebacks.
REQ-018 SHALL implement FSM states RUN and DRAIN.
REQ-019 SHALL, on flush_i in RUN, empty the FIFO at that edge. The next state is DRAIN if the post-update inflight is nonzero, else RUN.
REQ-020 SHALL, in DRAIN, accept no issues and send no requests. Responses decrement inflight but produce no writeback (wb_valid_o=0). The FSM returns to RUN in the cycle after inflight reaches 0.
REQ-021 SHALL, on flush_i in DRAIN, stay in DRAIN. A flush in the same cycle as an acc_resp_valid_i in RUN suppresses that response's writeback.
REQ-022 SHALL drive idle_o = (state==RUN) && empty && (inflight==0).

Reset
REQ-023 SHALL, while rst_i is high at a clk_i edge, set state=RUN, FIFO empty, pointers=0, inflight=0, wb_valid_o=0, wb_trans_id_o=0, wb_result_o=0, wb_ex_valid_o=0 and unexpected_resp_o=0. Outputs settle to issue_ready_o=1, acc_req_valid_o=0 and idle_o=1 after the edge.
REQ-024 SHALL let reset mid-operation override all activity, including flush/drain. Responses for pre-reset requests then count as unexpected.

Verification
REQ-025 Push instr 0x0000_000B trans_id 2 with acc_req_ready_i=1 -> acc_req_valid_o next cycle, inflight_o=1; response result 0x55 in cycle N -> wb_valid_o, wb_trans_id_o=2, wb_result_o=0x55 in N+1, inflight_o=0.
REQ-026 acc_req_ready_i=0, push 5 instrs with DEPTH=4 -> issue_ready_o low after 4th push, 5th held; ready=1 -> 4 requests in FIFO order with stable payload while stalled.
REQ-027 MAX_OUTSTANDING=2, no responses, 3 queued -> exactly 2 requests fire, inflight_o=2, third waits; one response -> third fires next cycle.
REQ-028 inflight=2, 1 queued, flush_i pulse -> FIFO empty, state DRAIN, issue_ready_o=0; 2 responses -> no wb_valid_o, RUN and idle_o=1 the cycle after the second.
REQ-029 Response with inflight=0 -> no writeback, unexpected_resp_o=1 until rst_i; request fire and response in same cycle at inflight=1 -> inflight_o stays 1.
